// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: registered, mode-sequenced driver for the century
// clock's 8-digit 7-segment display. Chooses TIME, DATE or an AUTO view
// that alternates between the two, blinks the field being edited, and
// optionally blanks the hour leading zero.
module display_mode_ctrl #(
  parameter int DWELL_TICKS = 5,
  parameter int BLINK_TICKS = 1,
  parameter int LZB         = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       edit_en,
  input  logic [2:0] edit_field,
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] hour_unit,
  input  logic [1:0] hour_ten,
  input  logic [3:0] day_unit,
  input  logic [1:0] day_ten,
  input  logic [3:0] month_unit,
  input  logic [1:0] month_ten,
  input  logic [3:0] year_unit,
  input  logic [3:0] year_ten,
  input  logic [3:0] year_hund,
  input  logic [3:0] year_thou,
  output logic [6:0] led0,
  output logic [6:0] led1,
  output logic [6:0] led2,
  output logic [6:0] led3,
  output logic [6:0] led4,
  output logic [6:0] led5,
  output logic [6:0] led6,
  output logic [6:0] led7,
  output logic       view,
  output logic       auto_on
);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    T_FIX  = 2'd0,
    D_FIX  = 2'd1,
    A_TIME = 2'd2,
    A_DATE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_ph;
  logic             view_nxt, auto_nxt;
  logic [6:0]       led_nxt [8];

  // Active-low {g..a} decode of one BCD digit; non-decimal values show a dash
  function automatic logic [6:0] bcd_to_led(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_led = 7'b1000000;
      4'd1:    bcd_to_led = 7'b1111001;
      4'd2:    bcd_to_led = 7'b0100100;
      4'd3:    bcd_to_led = 7'b0110000;
      4'd4:    bcd_to_led = 7'b0011001;
      4'd5:    bcd_to_led = 7'b0010010;
      4'd6:    bcd_to_led = 7'b0000010;
      4'd7:    bcd_to_led = 7'b1111000;
      4'd8:    bcd_to_led = 7'b0000000;
      4'd9:    bcd_to_led = 7'b0010000;
      default: bcd_to_led = SEG_DASH;
    endcase
  endfunction

  // Mode state and dwell counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= T_FIX;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

  // Next mode: the button always wins over dwell expiry and clears the dwell count
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell_cnt;
    case (state)
      T_FIX: begin
        dwell_nxt = '0;
        if (mode_btn) state_nxt = D_FIX;
      end
      D_FIX: begin
        dwell_nxt = '0;
        if (mode_btn) state_nxt = A_TIME;
      end
      A_TIME, A_DATE: begin
        if (mode_btn) begin
          state_nxt = T_FIX;
          dwell_nxt = '0;
        end else if (tick) begin
          if (dwell_cnt == DWELL_LAST) begin
            state_nxt = (state == A_TIME) ? A_DATE : A_TIME;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = T_FIX;
        dwell_nxt = '0;
      end
    endcase
  end

  // Blink phase generator; idle and showing digits whenever editing is off
  always_ff @(posedge clk) begin
    if (rst || !edit_en) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // Segment pattern for the current view, with blink and leading-zero blanking applied
  always_comb begin
    view_nxt = (state == T_FIX) || (state == A_TIME);
    auto_nxt = (state == A_TIME) || (state == A_DATE);
    for (int i = 0; i < 8; i++) led_nxt[i] = SEG_OFF;
    if (view_nxt) begin
      led_nxt[7] = SEG_DASH;
      led_nxt[6] = SEG_DASH;
      led_nxt[5] = bcd_to_led({2'b00, hour_ten});
      led_nxt[4] = bcd_to_led(hour_unit);
      led_nxt[3] = bcd_to_led(min_ten);
      led_nxt[2] = bcd_to_led(min_unit);
      led_nxt[1] = bcd_to_led(sec_ten);
      led_nxt[0] = bcd_to_led(sec_unit);
      if ((LZB != 0) && (hour_ten == 2'd0)) led_nxt[5] = SEG_OFF;
      if (blink_ph) begin
        case (edit_field)
          3'd0:    begin led_nxt[1] = SEG_OFF; led_nxt[0] = SEG_OFF; end
          3'd1:    begin led_nxt[3] = SEG_OFF; led_nxt[2] = SEG_OFF; end
          3'd2:    begin led_nxt[5] = SEG_OFF; led_nxt[4] = SEG_OFF; end
          default: ;
        endcase
      end
    end else begin
      led_nxt[7] = bcd_to_led({2'b00, day_ten});
      led_nxt[6] = bcd_to_led(day_unit);
      led_nxt[5] = bcd_to_led({2'b00, month_ten});
      led_nxt[4] = bcd_to_led(month_unit);
      led_nxt[3] = bcd_to_led(year_thou);
      led_nxt[2] = bcd_to_led(year_hund);
      led_nxt[1] = bcd_to_led(year_ten);
      led_nxt[0] = bcd_to_led(year_unit);
      if (blink_ph) begin
        case (edit_field)
          3'd3:    begin led_nxt[7] = SEG_OFF; led_nxt[6] = SEG_OFF; end
          3'd4:    begin led_nxt[5] = SEG_OFF; led_nxt[4] = SEG_OFF; end
          3'd5:    begin
            led_nxt[3] = SEG_OFF; led_nxt[2] = SEG_OFF;
            led_nxt[1] = SEG_OFF; led_nxt[0] = SEG_OFF;
          end
          default: ;
        endcase
      end
    end
  end

  // Output registers so the display pins change only on clock edges
  always_ff @(posedge clk) begin
    if (rst) begin
      led0    <= SEG_OFF;
      led1    <= SEG_OFF;
      led2    <= SEG_OFF;
      led3    <= SEG_OFF;
      led4    <= SEG_OFF;
      led5    <= SEG_OFF;
      led6    <= SEG_OFF;
      led7    <= SEG_OFF;
      view    <= 1'b1;
      auto_on <= 1'b0;
    end else begin
      led0    <= led_nxt[0];
      led1    <= led_nxt[1];
      led2    <= led_nxt[2];
      led3    <= led_nxt[3];
      led4    <= led_nxt[4];
      led5    <= led_nxt[5];
      led6    <= led_nxt[6];
      led7    <= led_nxt[7];
      view    <= view_nxt;
      auto_on <= auto_nxt;
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Testbench for display_mode_ctrl: directed vectors push hand-computed
// expectations into a scoreboard queue; a negedge monitor pops and compares.
module tb_display_mode_ctrl;

  localparam logic [6:0] OFF  = 7'h7F;
  localparam logic [6:0] DASH = 7'h3F;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10;

  localparam logic [55:0] ALL_OFF  = {8{OFF}};
  localparam logic [55:0] TIME_123456 = {DASH, DASH, S1, S2, S3, S4, S5, S6};
  localparam logic [55:0] TIME_HBLNK  = {DASH, DASH, OFF, OFF, S3, S4, S5, S6};
  localparam logic [55:0] DATE_311220 = {S3, S1, S1, S2, S2, S0, S9, S9};
  localparam logic [55:0] DATE_YBLNK  = {S3, S1, S1, S2, OFF, OFF, OFF, OFF};
  localparam logic [55:0] TIME_073456 = {DASH, DASH, OFF, S7, S3, S4, S5, S6};
  localparam logic [55:0] TIME_07345A = {DASH, DASH, OFF, S7, S3, S4, S5, DASH};

  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, mode_btn = 1'b0, edit_en = 1'b0;
  logic [2:0] edit_field = 3'd7;
  logic [3:0] sec_unit = 4'd6, sec_ten = 4'd5, min_unit = 4'd4, min_ten = 4'd3, hour_unit = 4'd2;
  logic [1:0] hour_ten = 2'd1, day_ten = 2'd3, month_ten = 2'd1;
  logic [3:0] day_unit = 4'd1, month_unit = 4'd2;
  logic [3:0] year_unit = 4'd9, year_ten = 4'd9, year_hund = 4'd0, year_thou = 4'd2;
  logic [6:0] led0, led1, led2, led3, led4, led5, led6, led7;
  logic view, auto_on;

  typedef struct {
    int          cyc;
    logic [55:0] leds;
    logic        view;
    logic        auto_on;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  display_mode_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn),
    .edit_en(edit_en), .edit_field(edit_field),
    .sec_unit(sec_unit), .sec_ten(sec_ten), .min_unit(min_unit), .min_ten(min_ten),
    .hour_unit(hour_unit), .hour_ten(hour_ten),
    .day_unit(day_unit), .day_ten(day_ten), .month_unit(month_unit), .month_ten(month_ten),
    .year_unit(year_unit), .year_ten(year_ten), .year_hund(year_hund), .year_thou(year_thou),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3),
    .led4(led4), .led5(led5), .led6(led6), .led7(led7),
    .view(view), .auto_on(auto_on)
  );

  // Free-running clock and cycle counter used to time-stamp expectations
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares it to the outputs
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if ({led7, led6, led5, led4, led3, led2, led1, led0} === e.leds &&
          view === e.view && auto_on === e.auto_on) begin
        pass_cnt++;
      end else begin
        $display("[TB] FAIL %s: got leds=%h view=%b auto_on=%b, expected leds=%h view=%b auto_on=%b",
                 e.name, {led7, led6, led5, led4, led3, led2, led1, led0}, view, auto_on,
                 e.leds, e.view, e.auto_on);
      end
    end
  end

  // Drive control inputs for n clock edges, then drop the one-cycle pulses
  task automatic applyStimulus(input logic r, input logic m, input logic t, input int n);
    rst = r;
    mode_btn = m;
    tick = t;
    repeat (n) @(posedge clk);
    #1;
    mode_btn = 1'b0;
    tick = 1'b0;
  endtask

  // Queue an expectation to be checked at this cycle's falling edge
  task automatic checkOutput(input string name, input logic [55:0] leds,
                             input logic v, input logic a);
    exp_t e;
    e.cyc = cyc;
    e.leds = leds;
    e.view = v;
    e.auto_on = a;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence
  initial begin
    applyStimulus(1, 0, 0, 2);
    checkOutput("reset", ALL_OFF, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("time_after_reset", TIME_123456, 1'b1, 1'b0);

    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("date_fixed", DATE_311220, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("auto_time", TIME_123456, 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("dwell_4_ticks", TIME_123456, 1'b1, 1'b1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("dwell_5th_tick_edge", TIME_123456, 1'b1, 1'b1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("auto_date", DATE_311220, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("auto_back_time", TIME_123456, 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
    end
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("btn_beats_dwell", TIME_123456, 1'b1, 1'b0);

    edit_en = 1'b1;
    edit_field = 3'd2;
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink_first_half", TIME_123456, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink_hour_off", TIME_HBLNK, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink_hour_on", TIME_123456, 1'b1, 1'b0);
    edit_field = 3'd4;
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink_month_in_time", TIME_123456, 1'b1, 1'b0);

    edit_field = 3'd5;
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink_year_in_date", DATE_YBLNK, 1'b0, 1'b0);
    edit_en = 1'b0;
    applyStimulus(0, 0, 0, 2);
    checkOutput("edit_off_date", DATE_311220, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_to_time", TIME_123456, 1'b1, 1'b0);

    hour_ten = 2'd0;
    hour_unit = 4'd7;
    applyStimulus(0, 0, 0, 1);
    checkOutput("lzb_hour_07", TIME_073456, 1'b1, 1'b0);
    sec_unit = 4'hA;
    applyStimulus(0, 0, 0, 1);
    checkOutput("invalid_digit_dash", TIME_07345A, 1'b1, 1'b0);

    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("reset_mid_auto", ALL_OFF, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("after_mid_reset", TIME_07345A, 1'b1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      total_cnt += exp_q.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
